// File: rtl/cp0_unit_pkg.sv
// Shared CP0 definitions: register numbers, ExcCode values, SR/Cause field positions.
// Also provides helpers that pack the architectural SR/Cause layouts.
package cp0_unit_pkg;

    localparam logic [4:0] CP0_SR    = 5'd12;
    localparam logic [4:0] CP0_CAUSE = 5'd13;
    localparam logic [4:0] CP0_EPC   = 5'd14;
    localparam logic [4:0] CP0_PRID  = 5'd15;

    localparam logic [4:0] EXC_INT  = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_RI   = 5'd10;
    localparam logic [4:0] EXC_OV   = 5'd12;

    localparam int SR_IE        = 0;
    localparam int SR_EXL       = 1;
    localparam int SR_IM_LO     = 10;
    localparam int CAUSE_EXC_LO = 2;
    localparam int CAUSE_IP_LO  = 10;
    localparam int CAUSE_BD     = 31;

    localparam logic [31:0] PRID_DEFAULT    = 32'h0000_7001;
    localparam logic [31:0] HANDLER_DEFAULT = 32'h0000_4180;

    function automatic logic [31:0] pack_sr(logic [5:0] im, logic exl, logic ie);
        logic [31:0] r;
        r                 = '0;
        r[SR_IM_LO +: 6]  = im;
        r[SR_EXL]         = exl;
        r[SR_IE]          = ie;
        return r;
    endfunction

    function automatic logic [31:0] pack_cause(logic bd, logic [5:0] ip, logic [4:0] exc);
        logic [31:0] r;
        r                     = '0;
        r[CAUSE_BD]           = bd;
        r[CAUSE_IP_LO +: 6]   = ip;
        r[CAUSE_EXC_LO +: 5]  = exc;
        return r;
    endfunction

endpackage

// File: rtl/cp0_unit_if.sv
// M-stage / bridge side of CP0: interrupt lines, exception info, mfc0/mtc0/eret, redirect.
// master = pipeline/bridge driving requests, slave = CP0 answering.
interface cp0_unit_if;
    logic [5:0]  hw_int;
    logic [4:0]  exc_code;
    logic [31:0] m_pc;
    logic        m_bd;
    logic        m_valid;
    logic [4:0]  rd_addr;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        we;
    logic        eret;
    logic [31:0] rd_data;
    logic        int_req;
    logic [31:0] next_pc;
    logic [31:0] epc_out;

    modport master (
        output hw_int, exc_code, m_pc, m_bd, m_valid,
        output rd_addr, wr_addr, wr_data, we, eret,
        input  rd_data, int_req, next_pc, epc_out
    );

    modport slave (
        input  hw_int, exc_code, m_pc, m_bd, m_valid,
        input  rd_addr, wr_addr, wr_data, we, eret,
        output rd_data, int_req, next_pc, epc_out
    );
endinterface

// File: rtl/cp0_int_arb.sv
// Interrupt/exception arbitration: decides int_req, picks ExcCode, computes the EPC word.
// Purely combinational, zero latency; no backpressure (sampled by cp0_unit each cycle).
import cp0_unit_pkg::*;

module cp0_int_arb (
    input  logic [5:0]  hw_int,
    input  logic [5:0]  im,
    input  logic        ie,
    input  logic        exl,
    input  logic        m_valid,
    input  logic [4:0]  exc_code,
    input  logic [31:2] m_pc_word,
    input  logic        m_bd,
    output logic        int_req,
    output logic [4:0]  exc_sel,
    output logic [31:2] epc_nxt
);

    logic irq;
    logic exc;

    // Live hw_int is used so a level raised this cycle is taken without the IP delay.
    assign irq     = (|(hw_int & im)) & ie & ~exl & m_valid;
    assign exc     = (exc_code != EXC_INT) & ~exl & m_valid;
    assign int_req = irq | exc;
    assign exc_sel = irq ? EXC_INT : exc_code;
    assign epc_nxt = m_bd ? (m_pc_word - 30'd1) : m_pc_word;

endmodule

// File: rtl/cp0_unit.sv
// System-control coprocessor: SR/Cause/EPC/PRId, flush request and handler/return PC.
// int_req/next_pc/rd_data combinational, state updates on the next edge; never stalls.
import cp0_unit_pkg::*;

module cp0_unit #(
    parameter logic [31:0] PRID_VAL   = PRID_DEFAULT,
    parameter logic [31:0] HANDLER_PC = HANDLER_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    cp0_unit_if.slave   bus
);

    logic [5:0]  im;
    logic        exl;
    logic        ie;
    logic        bd;
    logic [5:0]  ip;
    logic [4:0]  exc_q;
    logic [31:2] epc;

    logic        int_req;
    logic [4:0]  exc_sel;
    logic [31:2] epc_nxt;
    logic        wr_sr;
    logic        wr_epc;
    logic        unused_pc_lsb;

    cp0_int_arb u_arb (
        .hw_int    (bus.hw_int),
        .im        (im),
        .ie        (ie),
        .exl       (exl),
        .m_valid   (bus.m_valid),
        .exc_code  (bus.exc_code),
        .m_pc_word (bus.m_pc[31:2]),
        .m_bd      (bus.m_bd),
        .int_req   (int_req),
        .exc_sel   (exc_sel),
        .epc_nxt   (epc_nxt)
    );

    assign unused_pc_lsb = ^bus.m_pc[1:0];

    // A taken exception/interrupt squashes the M-stage mtc0 entirely.
    assign wr_sr  = bus.we && (bus.wr_addr == CP0_SR)  && !int_req;
    assign wr_epc = bus.we && (bus.wr_addr == CP0_EPC) && !int_req;

    always_ff @(posedge clk) begin
        if (reset) begin
            im    <= '0;
            exl   <= 1'b0;
            ie    <= 1'b0;
            bd    <= 1'b0;
            ip    <= '0;
            exc_q <= EXC_INT;
            epc   <= '0;
        end else begin
            ip <= bus.hw_int;
            if (int_req) begin
                exl   <= 1'b1;
                bd    <= bus.m_bd;
                epc   <= epc_nxt;
                exc_q <= exc_sel;
            end else begin
                if (wr_sr) begin
                    im  <= bus.wr_data[SR_IM_LO +: 6];
                    exl <= bus.wr_data[SR_EXL];
                    ie  <= bus.wr_data[SR_IE];
                end
                if (wr_epc) begin
                    epc <= bus.wr_data[31:2];
                end
                // Placed after the SR write so eret has the final say on EXL.
                if (bus.eret) begin
                    exl <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        bus.rd_data = '0;
        case (bus.rd_addr)
            CP0_SR:    bus.rd_data = pack_sr(im, exl, ie);
            CP0_CAUSE: bus.rd_data = pack_cause(bd, ip, exc_q);
            CP0_EPC:   bus.rd_data = {epc, 2'b00};
            CP0_PRID:  bus.rd_data = PRID_VAL;
            default:   bus.rd_data = '0;
        endcase
    end

    always_comb begin
        bus.next_pc = '0;
        if (int_req) begin
            bus.next_pc = HANDLER_PC;
        end else if (bus.eret) begin
            bus.next_pc = {epc, 2'b00};
        end
    end

    assign bus.int_req = int_req;
    assign bus.epc_out = {epc, 2'b00};

endmodule

// File: tb/tb_cp0_unit.sv
// Directed vector bench for cp0_unit: one table row per clock cycle, plus a short
// hand sequence for mtc0 EPC colliding with a taken interrupt.
`timescale 1ns/1ps
module tb_cp0_unit;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;

    cp0_unit_if bus ();

    cp0_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic [5:0]  hw;
        logic [4:0]  ec;
        logic [31:0] pc;
        logic        bd;
        logic        mv;
        logic        er;
        logic [4:0]  ra;
        logic        x_req;
        logic [31:0] x_npc;
        logic [31:0] x_rd;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic rst, logic we, logic [4:0] wa, logic [31:0] wd,
                                logic [5:0] hw, logic [4:0] ec, logic [31:0] pc,
                                logic bd, logic mv, logic er, logic [4:0] ra,
                                logic x_req, logic [31:0] x_npc, logic [31:0] x_rd);
        vec_t v;
        v.rst = rst; v.we = we; v.wa = wa; v.wd = wd; v.hw = hw; v.ec = ec;
        v.pc = pc; v.bd = bd; v.mv = mv; v.er = er; v.ra = ra;
        v.x_req = x_req; v.x_npc = x_npc; v.x_rd = x_rd;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s [%0d]: got %h, expected %h", name, idx, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        reset        = v.rst;
        bus.we       = v.we;
        bus.wr_addr  = v.wa;
        bus.wr_data  = v.wd;
        bus.hw_int   = v.hw;
        bus.exc_code = v.ec;
        bus.m_pc     = v.pc;
        bus.m_bd     = v.bd;
        bus.m_valid  = v.mv;
        bus.eret     = v.er;
        bus.rd_addr  = v.ra;
    endtask

    initial begin
        vec_t idle;
        n_checks = 0;
        n_fail   = 0;
        idle = mk(1'b1, 0, 5'd0, 32'h0, 6'h00, 5'd0, 32'h0, 0, 1, 0, 5'd0, 0, 32'h0, 32'h0);
        drive(idle);

        //          rst we wa      wd            hw     ec     pc            bd mv er ra      req npc           rd
        // reset state
        tbl.push_back(mk(0, 0, 5'd0,  32'h0,        6'h00, 5'd0,  32'h0,        0, 1, 0, 5'd12, 0, 32'h0,        32'h0));
        tbl.push_back(mk(0, 0, 5'd0,  32'h0,        6'h00, 5'd0,  32'h0,        0, 1, 0, 5'd13, 0, 32'h0,        32'h0));
        tbl.push_back(mk(0, 0, 5'd0,  32'h0,        6'h00, 5'd0,  32'h0,        0, 1, 0, 5'd14, 0, 32'h0,        32'h0));
        tbl.push_back(mk(0, 0, 5'd0,  32'h0,        6'h00, 5'd0,  32'h0,        0, 1, 0, 5'd15, 0, 32'h0,        32'h0000_7001));
        tbl.push_back(mk(0, 0, 5'd0,  32'h0,        6'h00, 5'd0,  32'h0,        0, 1, 0, 5'd0,  0, 32'h0,        32'h0));
        // basic interrupt, read-during-write returns old SR
        tbl.push_back(mk(0, 1, 5'd12, 32'h401,      6'h00, 5'd0,  32'h0,        0, 1, 0, 5'd12, 0, 32'h0,        32'h0));
        tbl.push_back(mk(0, 0, 5'd0,  32'h0,        6'h00, 5'd0,  32'h0,        0, 1, 0, 5'd12, 0, 32'h0,        32'h401));
        tbl.push_back(mk(0, 0, 5'd0,  32'h0,        6'h01, 5'd0,  32'h3010,     0, 1, 0, 5'd12, 1, 32'h4180,     32'h401));
        tbl.push_back(mk(0, 0, 5'd0,  32'h0,        6'h01, 5'd0,  32'h0,        0, 1, 0, 5'd14, 0, 32'h0,        32'h3010));
        tbl.push_back(mk(0, 0, 5'd0,  32'h0,        6'h01, 5'd0,  32'h0,        0, 1, 0, 5'd12, 0, 32'h0,        32'h403));
        tbl.push_back(mk(0, 0, 5'd0,  32'h0,        6'h01, 5'd0,  32'h0,        0, 1, 0, 5'd13, 0, 32'h0,        32'h400));
        // delay-slot interrupt
        tbl.push_back(mk(1, 0, 5'd0,  32'h0,        6'h00, 5'd0,  32'h0,        0, 1, 0, 5'd0,  0, 32'h0,        32'h0));
        tbl.push_back(mk(0, 1, 5'd12, 32'h401,      6'h00, 5'd0,  32'h0,        0, 1, 0, 5'd0,  0, 32'h0,        32'h0));
        tbl.push_back(mk(0, 0, 5'd0,  32'h0,        6'h01, 5'd0,  32'h3014,     1, 1, 0, 5'd0,  1, 32'h4180,     32'h0));
        tbl.push_back(mk(0, 0, 5'd0,  32'h0,        6'h01, 5'd0,  32'h0,        0, 1, 0, 5'd14, 0, 32'h0,        32'h3010));
        tbl.push_back(mk(0, 0, 5'd0,  32'h0,        6'h01, 5'd0,  32'h0,        0, 1, 0, 5'd13, 0, 32'h0,        32'h8000_0400));
        // EXL masks everything; eret returns, pending level taken after
        tbl.push_back(mk(0, 0, 5'd0,  32'h0,        6'h3f, 5'd12, 32'h5000,     0, 1, 0, 5'd14, 0, 32'h0,        32'h3010));
        tbl.push_back(mk(0, 0, 5'd0,  32'h0,        6'h3f, 5'd12, 32'h5000,     0, 1, 0, 5'd13, 0, 32'h0,        32'h8000_fc00));
        tbl.push_back(mk(0, 0, 5'd0,  32'h0,        6'h3f, 5'd12, 32'h5000,     0, 1, 1, 5'd12, 0, 32'h3010,     32'h403));
        tbl.push_back(mk(0, 0, 5'd0,  32'h0,        6'h3f, 5'd12, 32'h6000,     0, 1, 0, 5'd12, 1, 32'h4180,     32'h401));
        tbl.push_back(mk(0, 0, 5'd0,  32'h0,        6'h00, 5'd0,  32'h0,        0, 1, 0, 5'd13, 0, 32'h0,        32'h0000_fc00));
        tbl.push_back(mk(0, 0, 5'd0,  32'h0,        6'h00, 5'd0,  32'h0,        0, 1, 0, 5'd14, 0, 32'h0,        32'h6000));
        // interrupt beats same-cycle exception; then exception alone
        tbl.push_back(mk(1, 0, 5'd0,  32'h0,        6'h00, 5'd0,  32'h0,        0, 1, 0, 5'd0,  0, 32'h0,        32'h0));
        tbl.push_back(mk(0, 1, 5'd12, 32'h801,      6'h00, 5'd0,  32'h0,        0, 1, 0, 5'd12, 0, 32'h0,        32'h0));
        tbl.push_back(mk(0, 0, 5'd0,  32'h0,        6'h03, 5'd10, 32'h7000,     0, 1, 0, 5'd12, 1, 32'h4180,     32'h801));
        tbl.push_back(mk(0, 0, 5'd0,  32'h0,        6'h00, 5'd0,  32'h0,        0, 1, 0, 5'd13, 0, 32'h0,        32'h0000_0c00));
        tbl.push_back(mk(0, 0, 5'd0,  32'h0,        6'h00, 5'd0,  32'h0,        0, 1, 1, 5'd14, 0, 32'h7000,     32'h7000));
        tbl.push_back(mk(0, 0, 5'd0,  32'h0,        6'h00, 5'd10, 32'h7100,     0, 1, 0, 5'd12, 1, 32'h4180,     32'h801));
        tbl.push_back(mk(0, 0, 5'd0,  32'h0,        6'h00, 5'd0,  32'h0,        0, 1, 0, 5'd13, 0, 32'h0,        32'h28));
        tbl.push_back(mk(0, 0, 5'd0,  32'h0,        6'h00, 5'd0,  32'h0,        0, 1, 0, 5'd14, 0, 32'h0,        32'h7100));
        // read-only Cause/PRId, mtc0 squashed by int_req, mtc0 SR + eret
        tbl.push_back(mk(0, 1, 5'd13, 32'hffff_ffff, 6'h00, 5'd0, 32'h0,        0, 1, 0, 5'd13, 0, 32'h0,        32'h28));
        tbl.push_back(mk(0, 1, 5'd15, 32'h0,        6'h00, 5'd0,  32'h0,        0, 1, 0, 5'd13, 0, 32'h0,        32'h28));
        tbl.push_back(mk(0, 0, 5'd0,  32'h0,        6'h00, 5'd0,  32'h0,        0, 1, 0, 5'd15, 0, 32'h0,        32'h0000_7001));
        tbl.push_back(mk(0, 0, 5'd0,  32'h0,        6'h00, 5'd0,  32'h0,        0, 1, 1, 5'd0,  0, 32'h7100,     32'h0));
        tbl.push_back(mk(0, 1, 5'd12, 32'h0,        6'h02, 5'd0,  32'h7200,     0, 1, 0, 5'd12, 1, 32'h4180,     32'h801));
        tbl.push_back(mk(0, 0, 5'd0,  32'h0,        6'h02, 5'd0,  32'h0,        0, 1, 0, 5'd12, 0, 32'h0,        32'h803));
        tbl.push_back(mk(0, 1, 5'd12, 32'hffff_ffff, 6'h00, 5'd0, 32'h0,        0, 1, 1, 5'd14, 0, 32'h7200,     32'h7200));
        tbl.push_back(mk(0, 0, 5'd0,  32'h0,        6'h00, 5'd0,  32'h0,        0, 1, 0, 5'd12, 0, 32'h0,        32'h0000_fc01));
        tbl.push_back(mk(0, 1, 5'd14, 32'h1234_5677, 6'h00, 5'd0, 32'h0,        0, 1, 0, 5'd14, 0, 32'h0,        32'h7200));
        tbl.push_back(mk(0, 0, 5'd0,  32'h0,        6'h00, 5'd0,  32'h0,        0, 1, 0, 5'd14, 0, 32'h0,        32'h1234_5674));
        // bubble masks irq; reset mid-handler with hw_int held high
        tbl.push_back(mk(0, 0, 5'd0,  32'h0,        6'h04, 5'd0,  32'h0,        0, 0, 0, 5'd0,  0, 32'h0,        32'h0));
        tbl.push_back(mk(0, 0, 5'd0,  32'h0,        6'h04, 5'd0,  32'h8000,     0, 1, 0, 5'd0,  1, 32'h4180,     32'h0));
        tbl.push_back(mk(0, 0, 5'd0,  32'h0,        6'h04, 5'd0,  32'h0,        0, 1, 0, 5'd12, 0, 32'h0,        32'h0000_fc03));
        tbl.push_back(mk(1, 0, 5'd0,  32'h0,        6'h04, 5'd0,  32'h0,        0, 1, 0, 5'd12, 0, 32'h0,        32'h0000_fc03));
        tbl.push_back(mk(0, 0, 5'd0,  32'h0,        6'h04, 5'd0,  32'h0,        0, 1, 0, 5'd13, 0, 32'h0,        32'h0));
        tbl.push_back(mk(0, 0, 5'd0,  32'h0,        6'h04, 5'd0,  32'h0,        0, 1, 0, 5'd14, 0, 32'h0,        32'h0));
        tbl.push_back(mk(0, 0, 5'd0,  32'h0,        6'h04, 5'd0,  32'h0,        0, 1, 0, 5'd12, 0, 32'h0,        32'h0));

        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i]);
            @(negedge clk);
            chk("int_req", i, {31'b0, bus.int_req}, {31'b0, tbl[i].x_req});
            chk("next_pc", i, bus.next_pc, tbl[i].x_npc);
            chk("rd_data", i, bus.rd_data, tbl[i].x_rd);
            @(posedge clk);
            #1;
        end

        // mtc0 EPC in the same cycle as a taken interrupt: the interrupt's EPC lands
        idle = mk(0, 1, 5'd12, 32'h401, 6'h00, 5'd0, 32'h0, 0, 1, 0, 5'd0, 0, 32'h0, 32'h0);
        drive(idle);
        @(posedge clk);
        #1;
        idle = mk(0, 1, 5'd14, 32'haaaa_aaa8, 6'h01, 5'd0, 32'h9000, 0, 1, 0, 5'd13, 0, 32'h0, 32'h0);
        drive(idle);
        @(negedge clk);
        chk("seq_req", 0, {31'b0, bus.int_req}, 32'h1);
        chk("seq_epc_before", 0, bus.epc_out, 32'h0);
        @(posedge clk);
        #1;
        idle = mk(0, 0, 5'd0, 32'h0, 6'h00, 5'd0, 32'h0, 0, 1, 0, 5'd13, 0, 32'h0, 32'h0);
        drive(idle);
        @(negedge clk);
        chk("seq_epc_after", 1, bus.epc_out, 32'h9000);
        chk("seq_cause", 1, bus.rd_data, 32'h0000_0400);
        chk("seq_masked", 1, {31'b0, bus.int_req}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
